// File: rtl/logic2048_line_seq.sv
// logic2048_line_seq: slides and merges one line of 2048 tiles, one tile per cycle.
// Latency: fixed N+2 edges from the start edge to done rising; result held until the next done.
// Backpressure: none; start is only sampled in IDLE, and starts seen while busy are dropped.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, dir        request and slide direction (0 = toward tile 0, 1 = toward tile N-1)
//   line_in           N tiles of W-bit exponents, tile i at bits [i*W +: W]
//   busy, done        busy in SCAN/FLUSH; done is a one-cycle pulse when results update
//   line_out, moved, merges, overflow   registered results of the last completed operation
module logic2048_line_seq #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [N*W-1:0]        line_in,
  output logic                  busy,
  output logic                  done,
  output logic [N*W-1:0]        line_out,
  output logic                  moved,
  output logic [$clog2(N):0]    merges,
  output logic                  overflow
);

  localparam int IW = $clog2(N);      // scan index width
  localparam int PW = $clog2(N) + 1;  // write pointer can reach N
  localparam int MW = $clog2(N) + 1;
  localparam logic [W-1:0] TMAX = {W{1'b1}};

  typedef logic [N-1:0][W-1:0] line_t;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  function automatic line_t rev(input line_t l);
    line_t r;
    for (int i = 0; i < N; i++) r[i] = l[N-1-i];
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            dir_q, dir_d;
  line_t           cap_q, cap_d;       // captured line, already in scan order
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_vld_q, pend_vld_d;
  logic [W-1:0]    pend_q, pend_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  line_t           work_q, work_d;     // result under construction, scan order
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic            ovf_q, ovf_d;
  line_t           line_out_q, line_out_d;
  logic            moved_q, moved_d;
  logic [MW-1:0]   merges_q, merges_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  line_t           line_in_t;
  line_t           res_orig;
  line_t           cap_orig;
  logic [W-1:0]    tile;
  logic            wr_en;
  logic [W-1:0]    wr_val;

  assign line_in_t = line_in;
  assign tile      = cap_q[idx_q];
  assign res_orig  = dir_q ? rev(work_q) : work_q;
  assign cap_orig  = dir_q ? rev(cap_q) : cap_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cap_d      = cap_q;
    idx_d      = idx_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    wptr_d     = wptr_q;
    work_d     = work_q;
    mcnt_d     = mcnt_q;
    ovf_d      = ovf_q;
    line_out_d = line_out_q;
    moved_d    = moved_q;
    merges_d   = merges_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    wr_val     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d      = dir ? rev(line_in_t) : line_in_t;
          dir_d      = dir;
          idx_d      = '0;
          pend_vld_d = 1'b0;
          pend_d     = '0;
          wptr_d     = '0;
          work_d     = '0;
          mcnt_d     = '0;
          ovf_d      = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (tile != '0) begin
          if (!pend_vld_q) begin
            pend_d     = tile;
            pend_vld_d = 1'b1;
          end else if (pend_q == tile) begin
            // Merged tile goes straight to the output line and pending is
            // cleared, so it can never take part in a second merge.
            wr_en      = 1'b1;
            wr_val     = (tile == TMAX) ? TMAX : tile + W'(1);
            if (tile == TMAX) ovf_d = 1'b1;
            pend_vld_d = 1'b0;
            mcnt_d     = mcnt_q + MW'(1);
          end else begin
            wr_en  = 1'b1;
            wr_val = pend_q;
            pend_d = tile;
          end
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N-1)) state_d = FLUSH;
      end
      FLUSH: begin
        if (pend_vld_q) begin
          wr_en  = 1'b1;
          wr_val = pend_q;
        end
        pend_vld_d = 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        line_out_d = res_orig;
        moved_d    = (res_orig != cap_orig);
        merges_d   = mcnt_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (wptr_q == PW'(i)) work_d[i] = wr_val;
      end
      wptr_d = wptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      cap_q      <= '0;
      idx_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      wptr_q     <= '0;
      work_q     <= '0;
      mcnt_q     <= '0;
      ovf_q      <= 1'b0;
      line_out_q <= '0;
      moved_q    <= 1'b0;
      merges_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cap_q      <= cap_d;
      idx_q      <= idx_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      wptr_q     <= wptr_d;
      work_q     <= work_d;
      mcnt_q     <= mcnt_d;
      ovf_q      <= ovf_d;
      line_out_q <= line_out_d;
      moved_q    <= moved_d;
      merges_q   <= merges_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SCAN) || (state_q == FLUSH);
  assign done     = done_q;
  assign line_out = line_out_q;
  assign moved    = moved_q;
  assign merges   = merges_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_logic2048_line_seq.sv
// Directed bench for logic2048_line_seq with N=4, W=4.
// Each task drives one scenario and compares outputs against hand-computed values.
// Outputs are sampled 1ns after the rising edge or mid-cycle, never on the edge.
module tb_logic2048_line_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [15:0] line_in;
  logic        busy;
  logic        done;
  logic [15:0] line_out;
  logic        moved;
  logic [2:0]  merges;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic2048_line_seq #(.N(4), .W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dir      (dir),
    .line_in  (line_in),
    .busy     (busy),
    .done     (done),
    .line_out (line_out),
    .moved    (moved),
    .merges   (merges),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input int t0, input int t1, input int t2, input int t3);
    logic [3:0] a, b, c, d;
    a = 4'(t0); b = 4'(t1); c = 4'(t2); d = 4'(t3);
    return {d, c, b, a};
  endfunction

  // Issue one start and return the number of edges after the start edge at
  // which done was first seen (-1 if it never came within the budget).
  task automatic do_op(input logic d, input logic [15:0] l, output int lat);
    @(negedge clk);
    start = 1'b1; dir = d; line_in = l;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; dir = 1'b0; line_in = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (line_out !== 16'h0) begin errors++; $display("FAIL reset_line got %h exp 0000", line_out); end
    checks++; if ({moved, merges, overflow} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {moved, merges, overflow}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_merge();
    int lat;
    do_op(1'b0, pk(1,1,1,1), lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d exp 6", lat); end
    checks++; if (line_out !== pk(2,2,0,0)) begin errors++; $display("FAIL basic_line got %h exp %h", line_out, pk(2,2,0,0)); end
    checks++; if (merges !== 3'd2) begin errors++; $display("FAIL basic_merges got %0d exp 2", merges); end
    checks++; if ({moved, overflow} !== 2'b10) begin errors++; $display("FAIL basic_flags got %b exp 10", {moved, overflow}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %0b exp 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done); end
    checks++; if (line_out !== pk(2,2,0,0)) begin errors++; $display("FAIL basic_hold got %h exp %h", line_out, pk(2,2,0,0)); end
  endtask

  task automatic test_dir();
    int lat;
    do_op(1'b1, pk(2,2,2,0), lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL dir1_latency got %0d exp 6", lat); end
    checks++; if (line_out !== pk(0,0,2,3)) begin errors++; $display("FAIL dir1_line got %h exp %h", line_out, pk(0,0,2,3)); end
    checks++; if ({moved, merges, overflow} !== {1'b1, 3'd1, 1'b0}) begin errors++; $display("FAIL dir1_flags got %b exp 10010", {moved, merges, overflow}); end
    do_op(1'b0, pk(0,0,2,2), lat);
    checks++; if (line_out !== pk(3,0,0,0)) begin errors++; $display("FAIL dir0_gap_line got %h exp %h", line_out, pk(3,0,0,0)); end
    checks++; if ({moved, merges} !== {1'b1, 3'd1}) begin errors++; $display("FAIL dir0_gap_flags got %b exp 1001", {moved, merges}); end
    do_op(1'b1, pk(1,1,1,1), lat);
    checks++; if (line_out !== pk(0,0,2,2)) begin errors++; $display("FAIL dir1_all_line got %h exp %h", line_out, pk(0,0,2,2)); end
    checks++; if (merges !== 3'd2) begin errors++; $display("FAIL dir1_all_merges got %0d exp 2", merges); end
  endtask

  task automatic test_no_double_merge();
    int lat;
    do_op(1'b0, pk(2,2,3,0), lat);
    checks++; if (line_out !== pk(3,3,0,0)) begin errors++; $display("FAIL once_line got %h exp %h", line_out, pk(3,3,0,0)); end
    checks++; if (merges !== 3'd1) begin errors++; $display("FAIL once_merges got %0d exp 1", merges); end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(1'b0, pk(15,15,3,4), lat);
    checks++; if (line_out !== pk(15,3,4,0)) begin errors++; $display("FAIL ovf_line got %h exp %h", line_out, pk(15,3,4,0)); end
    checks++; if ({moved, merges, overflow} !== {1'b1, 3'd1, 1'b1}) begin errors++; $display("FAIL ovf_flags got %b exp 10011", {moved, merges, overflow}); end
  endtask

  task automatic test_unchanged();
    int lat;
    do_op(1'b0, pk(1,2,3,4), lat);
    checks++; if (line_out !== pk(1,2,3,4)) begin errors++; $display("FAIL same_line got %h exp %h", line_out, pk(1,2,3,4)); end
    checks++; if ({moved, merges, overflow} !== 5'b0) begin errors++; $display("FAIL same_flags got %b exp 00000", {moved, merges, overflow}); end
    do_op(1'b1, pk(0,0,0,0), lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL zero_latency got %0d exp 6", lat); end
    checks++; if ({line_out, moved} !== 17'h0) begin errors++; $display("FAIL zero_result got %h/%0b exp 0000/0", line_out, moved); end
  endtask

  task automatic test_ignore_start();
    int ndone;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; line_in = pk(1,1,0,0);
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %0b exp 1", busy); end
    @(negedge clk);
    start = 1'b1; line_in = pk(3,3,3,3); dir = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", ndone); end
    checks++; if (line_out !== pk(2,0,0,0)) begin errors++; $display("FAIL ign_line got %h exp %h", line_out, pk(2,0,0,0)); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(1'b0, pk(1,1,1,1), lat);
    // do_op's next start lands on edge E+N+3, the earliest legal restart.
    @(negedge clk);
    start = 1'b1; dir = 1'b0; line_in = pk(0,0,2,2);
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0b exp 1", busy); end
    @(posedge clk); #1;
    checks++; if (line_out !== pk(2,2,0,0)) begin errors++; $display("FAIL b2b_hold_line got %h exp %h", line_out, pk(2,2,0,0)); end
    checks++; if (merges !== 3'd2) begin errors++; $display("FAIL b2b_hold_merges got %0d exp 2", merges); end
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_latency got %0d exp 6", lat); end
    checks++; if (line_out !== pk(3,0,0,0)) begin errors++; $display("FAIL b2b_line got %h exp %h", line_out, pk(3,0,0,0)); end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int lat;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; line_in = pk(1,1,1,1);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_ctrl got %b exp 00", {busy, done}); end
    checks++; if (line_out !== 16'h0) begin errors++; $display("FAIL abort_line got %h exp 0000", line_out); end
    checks++; if ({moved, merges, overflow} !== 5'b0) begin errors++; $display("FAIL abort_flags got %b exp 00000", {moved, merges, overflow}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
    do_op(1'b0, pk(3,3,0,0), lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL post_rst_latency got %0d exp 6", lat); end
    checks++; if (line_out !== pk(4,0,0,0)) begin errors++; $display("FAIL post_rst_line got %h exp %h", line_out, pk(4,0,0,0)); end
    checks++; if ({moved, merges, overflow} !== {1'b1, 3'd1, 1'b0}) begin errors++; $display("FAIL post_rst_flags got %b exp 10010", {moved, merges, overflow}); end
  endtask

  initial begin
    test_reset();
    test_basic_merge();
    test_dir();
    test_no_double_merge();
    test_overflow();
    test_unchanged();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
